// File: rtl/doom_kb_pkg.sv
// Shared constants for the PS/2 movement-key path: scan codes, receiver states
// and slot indices into the held-key vectors.
package doom_kb_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    localparam logic [1:0] KEY_FWD   = 2'd0;
    localparam logic [1:0] KEY_BACK  = 2'd1;
    localparam logic [1:0] KEY_LEFT  = 2'd2;
    localparam logic [1:0] KEY_RIGHT = 2'd3;
    localparam int         NUM_KEYS  = 4;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } key_slot_t;

    // Arrow codes only count when they arrive behind an E0 prefix.
    function automatic key_slot_t arrow_slot(input logic [7:0] code);
        key_slot_t s;
        s = '{hit: 1'b1, idx: KEY_FWD};
        case (code)
            SC_UP:    s.idx = KEY_FWD;
            SC_DOWN:  s.idx = KEY_BACK;
            SC_LEFT:  s.idx = KEY_LEFT;
            SC_RIGHT: s.idx = KEY_RIGHT;
            default:  s.hit = 1'b0;
        endcase
        return s;
    endfunction

    function automatic key_slot_t wasd_slot(input logic [7:0] code);
        key_slot_t s;
        s = '{hit: 1'b1, idx: KEY_FWD};
        case (code)
            SC_W:    s.idx = KEY_FWD;
            SC_S:    s.idx = KEY_BACK;
            SC_A:    s.idx = KEY_LEFT;
            SC_D:    s.idx = KEY_RIGHT;
            default: s.hit = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ps2_move_keys_if.sv
// Keyboard lines in, held-key levels and byte status out. master = the decoder,
// slave = whatever drives the keyboard lines and consumes the levels.
interface ps2_move_keys_if;
    logic       kb_clock;
    logic       kb_dat;
    logic       turn_right;
    logic       turn_left;
    logic       move_forward;
    logic       move_backward;
    logic       key_valid;
    logic [7:0] key_code;
    logic       frame_error;

    modport master (
        input  kb_clock, kb_dat,
        output turn_right, turn_left, move_forward, move_backward,
        output key_valid, key_code, frame_error
    );

    modport slave (
        output kb_clock, kb_dat,
        input  turn_right, turn_left, move_forward, move_backward,
        input  key_valid, key_code, frame_error
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises kb_clock/kb_dat, samples on falling edges and
// reports each 11-bit frame as a good byte (byte_ok) or an error (err), both combinational strobes.
module ps2_frame_rx
    import doom_kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       kb_clock,
    input  logic       kb_dat,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       err
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SS-1:0] clk_sync;
    logic [SS-1:0] dat_sync;
    logic          clk_prev;
    logic          clk_s;
    logic          dat_s;
    logic          fall;

    rx_state_t     state_q;
    rx_state_t     state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;
    logic          good;
    logic          bad;

    // Idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a fake edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SS-2:0], kb_clock};
            dat_sync <= {dat_sync[SS-2:0], kb_dat};
            clk_prev <= clk_sync[SS-1];
        end
    end

    assign clk_s = clk_sync[SS-1];
    assign dat_s = dat_sync[SS-1];
    assign fall  = clk_prev & ~clk_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= RX_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        good        = 1'b0;
        bad         = 1'b0;
        timeout_hit = (state_q != RX_IDLE) && !fall && (to_cnt == TO_LAST);
        case (state_q)
            RX_IDLE:   if (fall && !dat_s) state_d = RX_DATA;
            RX_DATA:   if (fall && bit_cnt == 3'd7) state_d = RX_PARITY;
            RX_PARITY: if (fall) state_d = RX_STOP;
            RX_STOP: begin
                if (fall) begin
                    state_d = RX_IDLE;
                    if ((^{shift_q, parity_q}) && dat_s) good = 1'b1;
                    else                                 bad  = 1'b1;
                end
            end
            default:   state_d = RX_IDLE;
        endcase
        if (timeout_hit) state_d = RX_IDLE;
    end

    // Shift register, bit counter and the idle-clock watchdog.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            shift_q  <= 8'd0;
            parity_q <= 1'b0;
            to_cnt   <= '0;
        end else begin
            if (state_q == RX_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (state_q == RX_DATA && fall) begin
                shift_q[bit_cnt] <= dat_s;
                bit_cnt          <= bit_cnt + 3'd1;
            end
            if (state_q == RX_PARITY && fall) parity_q <= dat_s;
            if (state_q == RX_IDLE || fall || timeout_hit) to_cnt <= '0;
            else                                          to_cnt <= to_cnt + 1'b1;
        end
    end

    assign rx_byte = shift_q;
    assign byte_ok = good;
    assign err     = bad | timeout_hit;

endmodule

// File: rtl/ps2_move_keys.sv
// Arrow-key (and, with PS2_WASD_EN defined, WASD) held-level decoder on top of
// ps2_frame_rx; tracks E0/F0 prefixes and presents one level per movement.
module ps2_move_keys
    import doom_kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic            clock,
    input  logic            reset,
    ps2_move_keys_if.master bus
);

    logic [7:0]          rx_byte;
    logic                byte_ok;
    logic                err;
    logic                key_valid_q;
    logic [7:0]          key_code_q;
    logic                frame_error_q;
    logic                ext_q;
    logic                brk_q;
    logic [NUM_KEYS-1:0] arrow_held;
    logic [NUM_KEYS-1:0] letter_held;
    logic [NUM_KEYS-1:0] held;
    key_slot_t           arrow_hit;
    logic                plain_code;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clock   (clock),
        .reset   (reset),
        .kb_clock(bus.kb_clock),
        .kb_dat  (bus.kb_dat),
        .rx_byte (rx_byte),
        .byte_ok (byte_ok),
        .err     (err)
    );

    assign arrow_hit  = arrow_slot(rx_byte);
    assign plain_code = (rx_byte != SC_EXT) && (rx_byte != SC_BREAK);

    // Prefix flags and arrow levels; any frame error drops a half-received sequence.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'd0;
            frame_error_q <= 1'b0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            arrow_held    <= '0;
        end else begin
            key_valid_q   <= byte_ok;
            frame_error_q <= err;
            if (byte_ok) begin
                key_code_q <= rx_byte;
                if (rx_byte == SC_EXT) begin
                    ext_q <= 1'b1;
                end else if (rx_byte == SC_BREAK) begin
                    brk_q <= 1'b1;
                end else begin
                    if (ext_q && arrow_hit.hit) arrow_held[arrow_hit.idx] <= !brk_q;
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end else if (err) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

`ifdef PS2_WASD_EN
    key_slot_t letter_hit;
    assign letter_hit = wasd_slot(rx_byte);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            letter_held <= '0;
        end else if (byte_ok && plain_code && !ext_q && letter_hit.hit) begin
            letter_held[letter_hit.idx] <= !brk_q;
        end
    end
`else
    assign letter_held = '0;
`endif

    assign held              = arrow_held | letter_held;
    assign bus.move_forward  = held[KEY_FWD];
    assign bus.move_backward = held[KEY_BACK];
    assign bus.turn_left     = held[KEY_LEFT];
    assign bus.turn_right    = held[KEY_RIGHT];
    assign bus.key_valid     = key_valid_q;
    assign bus.key_code      = key_code_q;
    assign bus.frame_error   = frame_error_q;

endmodule

// File: tb/tb_ps2_move_keys.sv
// Scoreboard bench for ps2_move_keys: each frame sent pushes the expected byte
// event and key levels; a monitor pops and compares on every key_valid/frame_error.
module tb_ps2_move_keys;

    localparam int TIMEOUT = 300;
    localparam int HALF    = 25;

    logic clock = 1'b0;
    logic reset;

    ps2_move_keys_if bus ();

    ps2_move_keys #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_STAGES   (2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic [3:0] keys;
    } exp_t;

    exp_t       expq[$];
    int         testsRun    = 0;
    int         testsFailed = 0;
    bit         mExt, mBrk;
    logic [3:0] mArrow, mLetter;
    logic [7:0] mCode;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] dutKeys();
        return {bus.turn_right, bus.turn_left, bus.move_backward, bus.move_forward};
    endfunction

    task automatic modelReset();
        mExt = 0; mBrk = 0; mArrow = 4'b0; mLetter = 4'b0; mCode = 8'h00;
    endtask

    // Reference model: key bit 0 fwd, 1 back, 2 left, 3 right.
    task automatic modelByte(input logic [7:0] c, input bit bad);
        exp_t e;
        e.is_err = bad;
        if (bad) begin
            mExt = 0; mBrk = 0;
        end else begin
            mCode = c;
            if (c == 8'hE0) mExt = 1;
            else if (c == 8'hF0) mBrk = 1;
            else begin
                if (mExt) begin
                    case (c)
                        8'h75: mArrow[0] = !mBrk;
                        8'h72: mArrow[1] = !mBrk;
                        8'h6B: mArrow[2] = !mBrk;
                        8'h74: mArrow[3] = !mBrk;
                        default: ;
                    endcase
                end
`ifdef PS2_WASD_EN
                else begin
                    case (c)
                        8'h1D: mLetter[0] = !mBrk;
                        8'h1B: mLetter[1] = !mBrk;
                        8'h1C: mLetter[2] = !mBrk;
                        8'h23: mLetter[3] = !mBrk;
                        default: ;
                    endcase
                end
`endif
                mExt = 0; mBrk = 0;
            end
        end
        e.code = mCode;
        e.keys = mArrow | mLetter;
        expq.push_back(e);
    endtask

    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.kb_dat = bits[i];
            repeat (HALF) @(posedge clock);
            bus.kb_clock = 1'b0;
            repeat (HALF) @(posedge clock);
            bus.kb_clock = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] c, input bit badParity);
        logic p;
        p = (~^c) ^ badParity;
        modelByte(c, badParity);
        sendBits({1'b1, p, c, 1'b0}, 11);
        repeat (2 * HALF) @(posedge clock);
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n;
        n = 0;
        while (expq.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        repeat (4) @(posedge clock);
        checkOutput({tag, "_drain"}, 32'(expq.size()), 32'd0);
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && (bus.key_valid || bus.frame_error)) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_pulse", {30'd0, bus.key_valid, bus.frame_error}, 32'd0);
            end else begin
                e = expq.pop_front();
                checkOutput("frame_error", 32'(bus.frame_error), 32'(e.is_err));
                checkOutput("key_valid", 32'(bus.key_valid), 32'(!e.is_err));
                checkOutput("key_code", 32'(bus.key_code), 32'(e.code));
                checkOutput("keys", 32'(dutKeys()), 32'(e.keys));
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.kb_clock = 1'b1;
        bus.kb_dat   = 1'b1;
        modelReset();
        repeat (5) @(posedge clock);
        #1;
        checkOutput("rst_keys", 32'(dutKeys()), 32'd0);
        checkOutput("rst_code", 32'(bus.key_code), 32'd0);
        checkOutput("rst_valid", 32'(bus.key_valid), 32'd0);
        checkOutput("rst_err", 32'(bus.frame_error), 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clock);

        // Extended up arrow press, then release
        applyStimulus(8'hE0, 0);
        applyStimulus(8'h75, 0);
        waitDrain("t1", 200);
        checkOutput("t1_fwd", 32'(bus.move_forward), 32'd1);
        applyStimulus(8'hE0, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h75, 0);
        waitDrain("t2", 200);
        checkOutput("t2_fwd", 32'(bus.move_forward), 32'd0);

        // Keypad code without prefix is ignored
        applyStimulus(8'h75, 0);
        waitDrain("t3", 200);

        // Parity error clears the pending E0
        applyStimulus(8'hE0, 0);
        applyStimulus(8'h74, 1);
        applyStimulus(8'h74, 0);
        waitDrain("t4", 200);
        checkOutput("t4_right", 32'(bus.turn_right), 32'd0);

        // Abandoned frame times out
        modelByte(8'h00, 1);
        sendBits(11'b000_0000_1010, 5);
        waitDrain("t5_timeout", TIMEOUT + 200);
        applyStimulus(8'hE0, 0);
        applyStimulus(8'h6B, 0);
        waitDrain("t5", 200);
        checkOutput("t5_left", 32'(bus.turn_left), 32'd1);

        // Reset during a partial frame with keys held
        applyStimulus(8'hE0, 0);
        applyStimulus(8'h72, 0);
        waitDrain("t6", 200);
        checkOutput("t6_back", 32'(bus.move_backward), 32'd1);
        sendBits(11'b000_0000_0110, 4);
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("t6_rst_keys", 32'(dutKeys()), 32'd0);
        checkOutput("t6_rst_code", 32'(bus.key_code), 32'd0);
        repeat (3) @(posedge clock);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        applyStimulus(8'h1D, 0);
        waitDrain("t6_w", 200);
        checkOutput("t6_w_fwd", 32'(bus.move_forward), 32'(mArrow[0] | mLetter[0]));
        applyStimulus(8'hE0, 0);
        applyStimulus(8'h75, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h1D, 0);
        waitDrain("t6_mix", 400);
        checkOutput("t6_mix_fwd", 32'(bus.move_forward), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
